// File: rtl/led_page_ctrl.sv
// Debug 7-segment page/source controller: synchronised, debounced buttons select a 64-bit
// source and one of its 16-bit words. Optional auto page scan: define LED_PAGE_AUTO_SCAN_EN.
module led_page_ctrl #(
  parameter int NSRC        = 4,
  parameter int SW          = 2,
  parameter int DEB_CYCLES  = 50000,
  parameter int SCAN_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC*64-1:0] src_data,
  input  logic               btn_page,
  input  logic               btn_src,
  input  logic               freeze,
  input  logic               scan_en,
  output logic [15:0]        disp_word,
  output logic [1:0]         page,
  output logic [SW-1:0]      src_sel,
  output logic [3:0]         dp_n
);

  localparam int CW = $clog2(DEB_CYCLES);

  // Button index 0 = page, 1 = source
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         acc_q, acc_d;
  logic [1:0]         press_q, press_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  logic [1:0]    page_q, page_d;
  logic [SW-1:0] src_q, src_d;
  logic [63:0]   snap_q, snap_d;
  logic          reload_q, reload_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    dpn_q, dpn_d;
  logic          page_adv;

`ifdef LED_PAGE_AUTO_SCAN_EN
  localparam int TW = $clog2(SCAN_CYCLES);
  logic [TW-1:0] timer_q, timer_d;
  logic          scan_tc;
  assign scan_tc = scan_en && (timer_q == TW'(SCAN_CYCLES - 1));
`else
  logic unused_scan_en;
  assign unused_scan_en = scan_en;
`endif

  // Counter runs while the synchronised level disagrees with the accepted one
  always_comb begin
    acc_d   = acc_q;
    press_d = '0;
    cnt_d   = cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == acc_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CW'(DEB_CYCLES - 1)) begin
        cnt_d[b]   = '0;
        acc_d[b]   = sync2_q[b];
        press_d[b] = sync2_q[b];
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  always_comb begin
    page_d   = page_q;
    src_d    = src_q;
    snap_d   = snap_q;
    reload_d = press_q[1];
    page_adv = press_q[0];
`ifdef LED_PAGE_AUTO_SCAN_EN
    page_adv = press_q[0] | scan_tc;
    if (!scan_en || press_q[0] || press_q[1] || scan_tc) timer_d = '0;
    else                                                 timer_d = timer_q + 1'b1;
`endif
    // Source press wins over a coincident page advance
    if (press_q[1]) begin
      src_d  = (src_q == SW'(NSRC - 1)) ? '0 : src_q + 1'b1;
      page_d = 2'd0;
    end else if (page_adv) begin
      page_d = page_q + 2'd1;
    end
    if (!freeze || reload_q) snap_d = src_data[int'(src_q)*64 +: 64];
    disp_d = snap_q[(3 - int'(page_q))*16 +: 16];
    dpn_d  = ~(4'b1000 >> page_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      acc_q    <= '0;
      press_q  <= '0;
      cnt_q    <= '0;
      page_q   <= '0;
      src_q    <= '0;
      snap_q   <= '0;
      reload_q <= 1'b0;
      disp_q   <= '0;
      dpn_q    <= 4'b0111;
`ifdef LED_PAGE_AUTO_SCAN_EN
      timer_q  <= '0;
`endif
    end else begin
      sync1_q  <= {btn_src, btn_page};
      sync2_q  <= sync1_q;
      acc_q    <= acc_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
      page_q   <= page_d;
      src_q    <= src_d;
      snap_q   <= snap_d;
      reload_q <= reload_d;
      disp_q   <= disp_d;
      dpn_q    <= dpn_d;
`ifdef LED_PAGE_AUTO_SCAN_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign disp_word = disp_q;
  assign page      = page_q;
  assign src_sel   = src_q;
  assign dp_n      = dpn_q;

endmodule

// File: tb/tb_led_page_ctrl.sv
// Bench for led_page_ctrl: directed and random button/data stimulus against a word-level model.
module tb_led_page_ctrl;
  localparam int NSRC = 4;
  localparam int SW   = 2;
  localparam int DEB  = 4;
  localparam int SCAN = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [NSRC*64-1:0] src_data;
  logic               btn_page, btn_src, freeze, scan_en;
  logic [15:0]        disp_word;
  logic [1:0]         page;
  logic [SW-1:0]      src_sel;
  logic [3:0]         dp_n;

  always #5 clk = ~clk;

  led_page_ctrl #(.NSRC(NSRC), .SW(SW), .DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .btn_page(btn_page), .btn_src(btn_src),
    .freeze(freeze), .scan_en(scan_en), .disp_word(disp_word), .page(page),
    .src_sel(src_sel), .dp_n(dp_n)
  );

  logic [63:0] src_vals [NSRC];
  logic [63:0] exp_snap;
  int exp_page, exp_src;
  int checks = 0, failures = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_src();
    for (int k = 0; k < NSRC; k++) src_data[64*k +: 64] = src_vals[k];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [63:0] v, input int p);
    logic [63:0] s;
    s = v >> (16 * (3 - p));
    return s[15:0];
  endfunction

  function automatic logic [3:0] marker(input int p);
    logic [3:0] d;
    d = 4'hF;
    d[3-p] = 1'b0;
    return d;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_page"}, 64'(page), 64'(exp_page));
    chk({tag, "_src"},  64'(src_sel), 64'(exp_src));
    chk({tag, "_disp"}, 64'(disp_word), 64'(word_of(exp_snap, exp_page)));
    chk({tag, "_dpn"},  64'(dp_n), 64'(marker(exp_page)));
  endtask

  // Hold buttons for len cycles, release, then let release debounce and pipeline settle
  task automatic press(input bit bs, input bit bp, input int len);
    btn_src = bs; btn_page = bp;
    tick(len);
    btn_src = 1'b0; btn_page = 1'b0;
    tick(14);
  endtask

  task automatic model_press(input bit bs, input bit bp, input int len);
    if (len >= DEB) begin
      if (bs) begin
        exp_src  = (exp_src + 1) % NSRC;
        exp_page = 0;
      end else if (bp) begin
        exp_page = (exp_page + 1) % 4;
      end
    end
    if (!freeze || (bs && len >= DEB)) exp_snap = src_vals[exp_src];
  endtask

  task automatic do_press(input string tag, input bit bs, input bit bp, input int len);
    press(bs, bp, len);
    model_press(bs, bp, len);
    check_all(tag);
  endtask

`ifdef LED_PAGE_AUTO_SCAN_EN
  // Cycles until page changes; optionally drops btn_page after rel_at cycles
  task automatic wait_change(output int n, input int rel_at);
    logic [1:0] start;
    start = page;
    n = 0;
    while (page == start && n < 40) begin
      tick(1);
      n++;
      if (n == rel_at) btn_page = 1'b0;
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, act, k, len;
    reset = 1'b1; btn_page = 1'b0; btn_src = 1'b0; freeze = 1'b0; scan_en = 1'b0;
    src_vals[0] = 64'h0123_4567_89AB_CDEF;
    src_vals[1] = 64'hFEDC_BA98_7654_3210;
    src_vals[2] = {$urandom, $urandom};
    src_vals[3] = {$urandom, $urandom};
    drive_src();
    exp_page = 0; exp_src = 0; exp_snap = 64'h0;
    tick(3);
    check_all("reset");

    reset = 1'b0;
    tick(1);
    chk("rst_lat1_disp", 64'(disp_word), 64'h0);
    tick(1);
    chk("rst_lat2_disp", 64'(disp_word), 64'h0123);
    chk("rst_lat2_dpn", 64'(dp_n), 64'h7);
    exp_snap = src_vals[0];

    for (int i = 0; i < 4; i++) do_press("page_step", 1'b0, 1'b1, 10);
    chk("page_wrap_disp", 64'(disp_word), 64'h0123);

    do_press("glitch3", 1'b0, 1'b1, 3);
    do_press("pulse5", 1'b0, 1'b1, 5);
    do_press("to_page2", 1'b0, 1'b1, 10);
    do_press("src_adv", 1'b1, 1'b0, 10);
    chk("src_adv_fedc", 64'(disp_word), 64'hFEDC);

    // src_data -> disp_word takes exactly two clocks
    src_vals[1] = {$urandom, $urandom};
    drive_src();
    tick(1);
    chk("lat_old", 64'(disp_word), 64'(word_of(exp_snap, exp_page)));
    exp_snap = src_vals[1];
    tick(1);
    chk("lat_new", 64'(disp_word), 64'(word_of(exp_snap, exp_page)));

    freeze = 1'b1;
    tick(1);
    src_vals[1] = 64'h0;
    drive_src();
    tick(5);
    check_all("frozen_hold");
    freeze = 1'b0;
    tick(1);
    chk("unfreeze_lat1", 64'(disp_word), 64'(word_of(exp_snap, exp_page)));
    exp_snap = src_vals[1];
    tick(1);
    chk("unfreeze_lat2", 64'(disp_word), 64'h0);

    // Source change while frozen reloads once, then holds again
    freeze = 1'b1;
    do_press("frozen_src", 1'b1, 1'b0, 8);
    src_vals[2] = ~src_vals[2];
    drive_src();
    tick(4);
    check_all("frozen_src_hold");
    freeze = 1'b0;
    tick(3);
    exp_snap = src_vals[exp_src];
    check_all("frozen_src_release");

    do_press("pre_both", 1'b0, 1'b1, 8);
    do_press("both", 1'b1, 1'b1, 8);

    for (int i = 0; i < 24; i++) begin
      act = int'($urandom_range(0, 3));
      case (act)
        0: begin len = int'($urandom_range(5, 12)); do_press("rnd_page", 1'b0, 1'b1, len); end
        1: begin len = int'($urandom_range(1, 3));  do_press("rnd_glitch", $urandom_range(0, 1) == 1, 1'b1, len); end
        2: begin len = int'($urandom_range(5, 12)); do_press("rnd_src", 1'b1, 1'b0, len); end
        default: begin
          k = int'($urandom_range(0, NSRC - 1));
          src_vals[k] = {$urandom, $urandom};
          drive_src();
          tick(3);
          exp_snap = src_vals[exp_src];
          check_all("rnd_data");
        end
      endcase
    end

    // Reset mid-operation with a pending debounce count and a held snapshot
    do_press("pre_rst", 1'b0, 1'b1, 8);
    freeze = 1'b1;
    btn_page = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(2);
    btn_page = 1'b0;
    exp_page = 0; exp_src = 0; exp_snap = 64'h0;
    check_all("mid_rst");
    reset = 1'b0;
    tick(14);
    check_all("mid_rst_frozen");
    freeze = 1'b0;
    tick(2);
    exp_snap = src_vals[0];
    check_all("mid_rst_release");

`ifdef LED_PAGE_AUTO_SCAN_EN
    scan_en = 1'b1;
    wait_change(n, 0);
    chk("scan_first", 64'(n), 64'(SCAN));
    exp_page = (exp_page + 1) % 4;
    chk("scan_first_page", 64'(page), 64'(exp_page));
    wait_change(n, 0);
    chk("scan_second", 64'(n), 64'(SCAN));
    exp_page = (exp_page + 1) % 4;
    tick(4);
    btn_page = 1'b1;
    wait_change(n, 8);
    chk("scan_manual_lat", 64'(n), 64'(DEB + 3));
    exp_page = (exp_page + 1) % 4;
    chk("scan_manual_page", 64'(page), 64'(exp_page));
    wait_change(n, 8);
    btn_page = 1'b0;
    chk("scan_after_manual", 64'(n), 64'(SCAN));
    exp_page = (exp_page + 1) % 4;
    chk("scan_after_manual_page", 64'(page), 64'(exp_page));
    scan_en = 1'b0;
    tick(40);
    check_all("scan_off");
`else
    scan_en = 1'b1;
    tick(40);
    check_all("scan_ignored");
    scan_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
